sprite_descriptor_bank: RTL and testbench
=========================================

Name: sprite_descriptor_bank

Overview:
- Holds the per-frame sprite descriptors p1VGA, p2VGA and stageVGA that drive the VGA controller's sprite hit-test and layering.
- The game processor writes 16-bit fields into a shadow bank. On request, the bank is clipped and committed to the active outputs only at the start of vertical sync, so a frame never shows a half-updated sprite.
- Sits directly upstream of the VGA controller, on the same pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line; used for X clipping.
- V_ACTIVE, 480, visible lines per frame; used for Y clipping.

Ports:
- iVGA_CLK  input  1  pixel clock; all logic on its rising edge.
- iRST_n  input  1  asynchronous active-low reset.
- iVS  input  1  active-low vertical sync, the same signal fed to the VGA controller output.
- wr_en  input  1  shadow write strobe.
- wr_sel  input  2  target sprite: 0=P1, 1=P2, 2=stage, 3=reserved.
- wr_field  input  2  field to write: 0=X, 1=Y, 2=W, 3=H.
- wr_data  input  16  field value, unsigned.
- commit_req  input  1  one-cycle pulse requesting a commit at the next vsync.
- commit_pending  output  1  high while a commit is requested but not yet completed.
- commit_ack  output  1  one-cycle pulse when all three descriptors have been updated.
- frame_count  output  16  count of vsync falling edges, wraps.
- p1VGA  output  64  active P1 descriptor.
- p2VGA  output  64  active P2 descriptor.
- stageVGA  output  64  active stage descriptor.

Behaviour:
- Descriptor format is {X[63:48], Y[47:32], W[31:16], H[15:0]}. X and Y give the top-left pixel. A descriptor with W=0 or H=0 is disabled.
- Reset: clears all shadow and active descriptors to 0, clears commit_pending and commit_ack to 0, sets frame_count to 0, sets the FSM to IDLE and clears the vsync history register to 1. Reset mid-commit abandons the commit; active outputs read 0.
- Shadow write: when wr_en=1 and wr_sel!=3, shadow[wr_sel].field is loaded on the same edge. wr_sel=3 is ignored. Writes are accepted in every FSM state.
- vs_fall = vs_d & ~iVS, where vs_d is iVS registered on the previous edge. frame_count increments (mod 2^16) on each edge where vs_fall=1, independent of FSM state.
- FSM states: IDLE, PENDING, CP1, CP2, CST, ACK.
  - IDLE: commit_req=1 -> PENDING. A vs_fall in the same cycle does not commit; the commit waits for the next vsync.
  - PENDING: vs_fall=1 -> CP1. commit_req is ignored (merged into the pending commit).
  - CP1: loads p1VGA from clip(shadow P1) -> CP2.
  - CP2: loads p2VGA from clip(shadow P2) -> CST.
  - CST: loads stageVGA from clip(shadow stage) -> ACK.
  - ACK: commit_ack=1 for exactly this cycle -> IDLE. A commit_req seen in ACK -> PENDING instead of IDLE.
- commit_pending=1 in PENDING, CP1, CP2 and CST; 0 otherwise.
- Latency: if the vs_fall edge is edge E, p1VGA updates at E+1, p2VGA at E+2, stageVGA at E+3, and commit_ack is high between E+3 and E+4.
- Copy sampling: each copy state samples the shadow value held before that edge. A write to the same sprite on the copy edge lands in the shadow only and is not committed this frame.
- clip(d):
  - If X>=H_ACTIVE, Y>=V_ACTIVE, W=0 or H=0, the result is 64'h0 (disabled).
  - Otherwise X and Y pass through unchanged, W'=min(W, H_ACTIVE-X) and H'=min(H, V_ACTIVE-Y).
  - All arithmetic is 16-bit unsigned; the subtractions cannot underflow because the X/Y range check precedes them.
- Active outputs are registers and change only in CP1, CP2 or CST, or at reset.

Test Plan:
- Reset, then write P1 X=100, Y=50, W=32, H=64 with no commit_req, then toggle iVS over two frames -> p1VGA stays 64'h0, frame_count=2, commit_ack never pulses.
- Same writes, then commit_req pulse, then iVS 1->0 at edge E -> commit_pending=1 until E+3; p1VGA=0x0064_0032_0020_0040 at E+1; commit_ack high for the single cycle E+3..E+4.
- Stage X=600, Y=460, W=100, H=100, then commit -> stageVGA=0x0258_01CC_0028_0014. P2 X=640, W=10, H=10, then commit -> p2VGA=64'h0.
- commit_req in the same cycle as vs_fall while IDLE -> no copy this frame; copy starts on the following vs_fall. Three commit_req pulses while PENDING -> exactly one commit_ack.
- Write P2 W=8 on edge E+2 (the CP2 copy edge) after committing W=4 -> p2VGA.W=4 this frame; the next commit gives W=8.
- Assert iRST_n=0 during CP2 -> all outputs 0 and FSM in IDLE. After release, a 65536th vs_fall wraps frame_count to 0.

Source files
------------

// File: rtl/sprite_descriptor_bank.sv
// sprite_descriptor_bank: shadowed sprite descriptors, clipped and committed to the VGA outputs at vsync
module sprite_descriptor_bank #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iVS,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [1:0]  wr_field,
  input  logic [15:0] wr_data,
  input  logic        commit_req,
  output logic        commit_pending,
  output logic        commit_ack,
  output logic [15:0] frame_count,
  output logic [63:0] p1VGA,
  output logic [63:0] p2VGA,
  output logic [63:0] stageVGA
);
  typedef enum logic [2:0] {IDLE, PENDING, CP1, CP2, CST, ACK} state_t;
  state_t state, state_n;
  logic [63:0] shadow [3];
  logic        vs_d;
  logic        vs_fall;

  function automatic logic [63:0] clip(input logic [63:0] d);
    logic [15:0] x, y, w, h, wm, hm;
    x  = d[63:48];
    y  = d[47:32];
    w  = d[31:16];
    h  = d[15:0];
    wm = 16'(H_ACTIVE) - x;
    hm = 16'(V_ACTIVE) - y;
    return (x >= 16'(H_ACTIVE) || y >= 16'(V_ACTIVE) || w == '0 || h == '0) ? 64'h0 :
           {x, y, (w < wm) ? w : wm, (h < hm) ? h : hm};
  endfunction

  assign vs_fall        = vs_d & ~iVS;
  assign commit_pending = state inside {PENDING, CP1, CP2, CST};
  assign commit_ack     = state == ACK;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = commit_req ? PENDING : IDLE;
      PENDING: state_n = vs_fall ? CP1 : PENDING;
      CP1:     state_n = CP2;
      CP2:     state_n = CST;
      CST:     state_n = ACK;
      ACK:     state_n = commit_req ? PENDING : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state       <= IDLE;
      vs_d        <= 1'b1;
      frame_count <= '0;
      p1VGA       <= '0;
      p2VGA       <= '0;
      stageVGA    <= '0;
      for (int i = 0; i < 3; i++) shadow[i] <= '0;
    end else begin
      state <= state_n;
      vs_d  <= iVS;
      if (vs_fall) frame_count <= frame_count + 16'd1;
      // copies read the shadow as it stood before this edge
      if (state == CP1) p1VGA <= clip(shadow[0]);
      if (state == CP2) p2VGA <= clip(shadow[1]);
      if (state == CST) stageVGA <= clip(shadow[2]);
      if (wr_en && wr_sel != 2'd3) shadow[wr_sel][{~wr_field, 4'b0} +: 16] <= wr_data;
    end
  end
endmodule

// File: tb/tb_sprite_descriptor_bank.sv
// tb_sprite_descriptor_bank: directed and random checks against a cycle-level reference model
module tb_sprite_descriptor_bank;
  logic        iVGA_CLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iVS = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = '0;
  logic [1:0]  wr_field = '0;
  logic [15:0] wr_data = '0;
  logic        commit_req = 1'b0;
  logic        commit_pending, commit_ack;
  logic [15:0] frame_count;
  logic [63:0] p1VGA, p2VGA, stageVGA;

  sprite_descriptor_bank dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iVS(iVS), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_field(wr_field), .wr_data(wr_data), .commit_req(commit_req),
    .commit_pending(commit_pending), .commit_ack(commit_ack), .frame_count(frame_count),
    .p1VGA(p1VGA), .p2VGA(p2VGA), .stageVGA(stageVGA)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  int n_tests = 0;
  int n_fail = 0;
  int unsigned sh [3][4];
  logic [63:0] m_act [3];
  bit armed, m_vsd;
  int fire, cyc, m_fc, acks;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_clip(input int unsigned x, y, w, h);
    int unsigned cw, ch;
    if (x >= 640 || y >= 480 || w == 0 || h == 0) return 64'h0;
    cw = (w > 640 - x) ? 640 - x : w;
    ch = (h > 480 - y) ? 480 - y : h;
    return {x[15:0], y[15:0], cw[15:0], ch[15:0]};
  endfunction

  task automatic model_reset();
    foreach (sh[i, j]) sh[i][j] = 0;
    foreach (m_act[i]) m_act[i] = '0;
    armed = 0;
    fire = -100;
    m_vsd = 1;
    m_fc = 0;
    cyc = 0;
  endtask

  task automatic check_all(input string tag);
    int ph;
    ph = cyc - fire;
    check({tag, ".p1"}, p1VGA, m_act[0]);
    check({tag, ".p2"}, p2VGA, m_act[1]);
    check({tag, ".st"}, stageVGA, m_act[2]);
    check({tag, ".pend"}, 64'(commit_pending), 64'(armed || (ph >= 0 && ph <= 2)));
    check({tag, ".ack"}, 64'(commit_ack), 64'(ph == 3));
    check({tag, ".fc"}, 64'(frame_count), 64'(m_fc));
  endtask

  // A commit fires on the first vsync fall after a request is armed; copies follow one sprite per cycle.
  task automatic tick(input string tag = "cyc");
    int ph;
    bit vf, busy;
    @(posedge iVGA_CLK);
    cyc++;
    ph = cyc - fire;
    vf = m_vsd && !iVS;
    busy = ph >= 1 && ph <= 3;
    if (busy) m_act[ph-1] = ref_clip(sh[ph-1][0], sh[ph-1][1], sh[ph-1][2], sh[ph-1][3]);
    if (armed && vf) begin
      fire = cyc;
      armed = 0;
    end else if (!busy && !armed && commit_req) armed = 1;
    if (wr_en && wr_sel != 2'd3) sh[wr_sel][wr_field] = wr_data;
    if (vf) m_fc = (m_fc + 1) % 65536;
    m_vsd = iVS;
    #1;
    if (commit_ack) acks++;
    check_all(tag);
  endtask

  task automatic wr(input int s, f, d);
    wr_en = 1; wr_sel = 2'(s); wr_field = 2'(f); wr_data = 16'(d);
    tick("wr");
    wr_en = 0;
  endtask

  task automatic wr4(input int s, x, y, w, h);
    wr(s, 0, x); wr(s, 1, y); wr(s, 2, w); wr(s, 3, h);
  endtask

  task automatic req();
    commit_req = 1;
    tick("req");
    commit_req = 0;
  endtask

  task automatic frame();
    iVS = 0;
    repeat (2) tick("vs");
    iVS = 1;
    repeat (5) tick("fr");
  endtask

  task automatic do_reset();
    iRST_n = 0;
    model_reset();
    #1;
    check_all("rst");
    repeat (2) @(posedge iVGA_CLK);
    @(negedge iVGA_CLK);
    iRST_n = 1;
  endtask

  initial begin
    int a0;
    model_reset();
    acks = 0;
    #2;
    do_reset();
    // no commit: outputs stay cleared while frames go by
    wr4(0, 100, 50, 32, 64);
    frame(); frame();
    check("nocommit.fc", 64'(frame_count), 64'd2);
    check("nocommit.p1", p1VGA, 64'h0);
    check("nocommit.acks", 64'(acks), 64'd0);
    // commit with explicit latency checks
    req();
    iVS = 0;
    tick("E");
    check("E.pend", 64'(commit_pending), 64'd1);
    iVS = 1;
    tick("E1");
    check("E1.p1", p1VGA, 64'h0064_0032_0020_0040);
    tick("E2");
    tick("E3");
    check("E3.ack", 64'(commit_ack), 64'd1);
    tick("E4");
    check("E4.ack", 64'(commit_ack), 64'd0);
    // right/bottom clipping and off-screen disable
    wr4(2, 600, 460, 100, 100);
    wr4(1, 640, 0, 10, 10);
    req(); frame();
    check("clip.stage", stageVGA, 64'h0258_01CC_0028_0014);
    check("clip.p2", p2VGA, 64'h0);
    // request coinciding with vsync fall in IDLE waits a frame
    wr4(0, 1, 2, 3, 4);
    commit_req = 1; iVS = 0;
    tick("same");
    commit_req = 0;
    tick("same1"); iVS = 1;
    repeat (4) tick("same2");
    check("same.p1", p1VGA, 64'h0064_0032_0020_0040);
    frame();
    check("same.p1b", p1VGA, 64'h0001_0002_0003_0004);
    // merged requests
    a0 = acks;
    req(); req(); req();
    frame();
    check("merge.acks", 64'(acks - a0), 64'd1);
    // write on the copy edge reaches only the shadow
    wr4(1, 10, 10, 4, 4);
    req();
    iVS = 0; tick("c0");
    iVS = 1; tick("c1");
    wr(1, 2, 8);
    repeat (4) tick("c3");
    check("copyedge.w", 64'(p2VGA[31:16]), 64'd4);
    req(); frame();
    check("copyedge.w2", 64'(p2VGA[31:16]), 64'd8);
    // reset while copying P2
    req();
    iVS = 0; tick("r0");
    iVS = 1; tick("r1");
    do_reset();
    check("rst.p1", p1VGA, 64'h0);
    check("rst.pend", 64'(commit_pending), 64'd0);
    repeat (4) tick("postrst");
    frame();
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_sel = 2'($urandom_range(0, 3));
      wr_field = 2'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 700));
      commit_req = ($urandom_range(0, 5) == 0);
      iVS = ($urandom_range(0, 4) != 0);
      tick("rnd");
    end
    wr_en = 0; commit_req = 0; iVS = 1;
    repeat (6) tick("tail");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
